moore_0101: RTL and testbench
=============================

// Module: moore_0101
// PURPOSE
//   Moore FSM that detects the serial bit sequence 0-1-0-1 on input x.
//   Overlapping occurrences are detected. One bit is sampled per rising clk edge.
//   Output y depends only on the current state, so it asserts one cycle after the
//   edge that samples the final '1'. Leaf block for serial-pattern detection.
// PARAMETERS
//   none. State encoding uses local constants only.
// PORTS (positional order is fixed: y, x, clk, reset)
//   clk    in   1  rising-edge clock; the only clock.
//   reset  in   1  asynchronous, active-low reset (0 = reset).
//   y      out  1  1 while the FSM is in state S0101 (pattern just completed).
//   x      in   1  serial data bit, sampled on posedge clk.
//   Note: the port list is declared as (y, x, clk, reset). y is first positionally.
// BEHAVIOUR
//   - Reset: when reset=0, the state goes to IDLE immediately, independent of clk.
//     y=0 throughout reset. The state is held while reset=0.
//   - Release of reset (0->1) is asynchronous.
//     The first transition happens at the first posedge clk with reset=1.
//   - States (one per matched prefix length):
//     IDLE (none), S0 ("0"), S01 ("01"), S010 ("010"), S0101 ("0101").
//   - Transitions on posedge clk (x=0 / x=1):
//       IDLE : S0   / IDLE
//       S0   : S0   / S01
//       S01  : S010 / IDLE
//       S010 : S0   / S0101
//       S0101: S010 / IDLE   (overlap: trailing "010" is reused)
//   - Output: y = (state == S0101). Moore only; x has no combinational path to y.
//   - Latency: y rises after the posedge that samples the final '1'.
//     It stays high exactly one cycle per detection.
//   - Back-to-back 0101 01: y pulses every 2 cycles once the first match occurs.
//   - Illegal or unused state encodings return to IDLE on the next posedge.
//     y=0 in any such state.
//   - Reset asserted mid-sequence discards all partial progress.
//     Reset asserted while y=1 clears y asynchronously.
//   - Implementation: a 3-bit state register (async-clear always block) plus a
//     combinational next-state/output block with a default branch.
// STRUCTURE
//   - Single module, no sub-modules.
//   - State encodings are localparams (IDLE=0 .. S0101=4).
//     Move them to a shared package only if other serial detectors reuse them.
// TESTING
//   - Reset: reset=0 at t=0, x arbitrary, clk toggling -> y=0 and state IDLE.
//     Asserting reset between edges clears y with no clk edge.
//   - Basic match: after reset, x = 0,0,1,0,1 on successive posedges -> y=0,0,0,0,1.
//     y=1 after the 5th edge.
//   - Overlap: continue with x = 0,1,0,1 -> y = 0,1,0,1.
//     y is high after every second edge.
//   - Non-match: x = 1,1,0,1,1,0,0,1,1 -> y stays 0 throughout.
//     Checks S01 and S0101 exits on x=1.
//   - Recovery: x = 0,1,0,0,1,0,1 -> y=1 only after the 7th edge.
//     Checks S010 going to S0 on x=0.
//   - Mid-sequence reset: x = 0,1,0, then reset pulse low, then x=1 -> y=0.
//     The partial match is lost; 0,1,0,1 must be re-sent to get y=1.

Source files
------------

// File: rtl/moore_0101_pkg.sv
// -----------------------------------------------------------------------------
// moore_0101_pkg
//   State type and encodings for the 0-1-0-1 serial pattern detector.
//   Each state stands for the length of the pattern prefix matched so far.
//   The values are fixed at 0..4 inside a 3-bit register. Codes 5..7 are unused.
// -----------------------------------------------------------------------------
package moore_0101_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,   // nothing matched
      S0    = 3'd1,   // "0"
      S01   = 3'd2,   // "01"
      S010  = 3'd3,   // "010"
      S0101 = 3'd4    // "0101" -- pattern complete, y asserted
   } state_t;

endpackage : moore_0101_pkg

// File: rtl/moore_0101.sv
// -----------------------------------------------------------------------------
// moore_0101
//   Moore FSM that detects the serial sequence 0-1-0-1 on x.
//   Overlapping occurrences are detected: after a match, the trailing "01" is
//   reused, so "010101" produces two detections.
//
// Ports (positional order y, x, clk, reset):
//   y     out  1  high while the FSM is in S0101 (pattern just completed)
//   x     in   1  serial data bit, sampled on the rising edge of clk
//   clk   in   1  rising-edge clock
//   reset in   1  asynchronous active-low reset (0 = reset, state -> IDLE)
// -----------------------------------------------------------------------------
module moore_0101
   import moore_0101_pkg::*;
(
   output logic y,
   input  logic x,
   input  logic clk,
   input  logic reset
);

   state_t state_reg;
   state_t state_next;

   // State register; clears asynchronously and holds IDLE while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and output logic. y is decoded from the state alone, so there
   // is no combinational path from x to y.
   always_comb begin
      state_next = IDLE;
      y          = 1'b0;
      case (state_reg)
         IDLE:    state_next = x ? IDLE  : S0;
         S0:      state_next = x ? S01   : S0;
         S01:     state_next = x ? IDLE  : S010;
         S010:    state_next = x ? S0101 : S0;
         S0101: begin
            y          = 1'b1;
            // On x=0 the "010" at the tail of the match is reused for overlap.
            state_next = x ? IDLE : S010;
         end
         // Codes 5..7 are unused. They fall back to IDLE with y low.
         default: state_next = IDLE;
      endcase
   end

endmodule : moore_0101

// File: tb/tb_moore_0101.sv
// -----------------------------------------------------------------------------
// tb_moore_0101
//   Directed-vector bench for moore_0101. Each vector is an x bit sequence
//   paired with the hand-computed y expected after each rising edge.
//   The sequences are written MSB first.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_moore_0101;

   logic clk;
   logic reset;
   logic x;
   logic y;

   int n_checks;
   int n_fails;

   moore_0101 dut (
      .y     (y),
      .x     (x),
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("FAIL %s: y=%b expected %b at t=%0t", tag, actual, expected, $time);
      end
   endtask

   // Apply n bits of xs (MSB first), one per rising edge. After each edge,
   // compare y with the matching bit of ys. The caller must enter this task
   // just after a rising edge.
   task automatic run_seq(input string tag, input logic [15:0] xs,
                          input logic [15:0] ys, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         x = xs[i];
         @(posedge clk);
         #1;
         check_bit($sformatf("%s[%0d] x=%b", tag, n - 1 - i, xs[i]), y, ys[i]);
         $display("%s step %0d: x=%b y=%b (exp %b)", tag, n - 1 - i, xs[i], y, ys[i]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset    = 1'b0;
      x        = 1'b1;

      // Hold reset across several edges while x toggles; y must stay low.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         x = ~x;
         check_bit($sformatf("reset_hold[%0d]", i), y, 1'b0);
      end
      reset = 1'b1;
      #1;
      check_bit("reset_release", y, 1'b0);
      @(posedge clk);
      #1;
      // After the edge above with x=1 the FSM is still in IDLE.
      check_bit("idle_after_release", y, 1'b0);

      run_seq("basic",    16'b0_0101,      16'b0_0001,      5);
      run_seq("overlap",  16'b0101,        16'b0101,        4);
      run_seq("nonmatch", 16'b1_1011_0011, 16'b0_0000_0000, 9);
      run_seq("recovery", 16'b010_0101,    16'b000_0001,    7);

      // Mid-sequence reset. Send 1 to return to IDLE, then send "010".
      // Pulse reset between edges. The final 1 must not complete a match.
      run_seq("pre_mid",  16'b1010,        16'b0000,        4);
      reset = 1'b0;
      #2;
      check_bit("mid_reset_low", y, 1'b0);
      reset = 1'b1;
      run_seq("post_mid", 16'b1,           16'b0,           1);
      run_seq("resend",   16'b0101,        16'b0001,        4);

      // y is high here. Asserting reset between edges must clear it at once.
      check_bit("y_high_before_async", y, 1'b1);
      reset = 1'b0;
      #1;
      check_bit("async_clear", y, 1'b0);
      x = 1'b1;
      @(posedge clk);
      #1;
      check_bit("async_hold", y, 1'b0);
      reset = 1'b1;
      run_seq("after_async", 16'b0101, 16'b0001, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, limit 100000 ns");
      $fatal(1, "timeout");
   end

endmodule : tb_moore_0101
